alu_cmd_sequencer: RTL

//   Initiator side of the 4-bit ALU operand/result interface. Accepts operation commands
//   (a, b, sel) over a valid/ready port and buffers them in a small FIFO. Drives one command
//   at a time onto the ALU inputs, captures the combinational ALU result and returns it with

---
 rtl/alu_cmd_sequencer_if.sv | 41 ++++
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Interface bundling the command, ALU and result ports of the ALU command sequencer.
// The sequencer connects through the slave modport.
// The master modport belongs to whatever drives commands and plays the ALU.
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 4,
    parameter int OUT_W  = 9
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [SEL_W-1:0]  cmd_sel;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [OUT_W-1:0]  alu_out;

    logic              res_valid;
    logic              res_ready;
    logic [OUT_W-1:0]  res_data;
    logic [SEL_W-1:0]  res_sel;
    logic              res_zero;
    logic              res_err;

    logic              busy;
    logic [7:0]        cmd_count;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data,
               res_sel, res_zero, res_err, busy, cmd_count
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_out, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data,
               res_sel, res_zero, res_err, busy, cmd_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: buffers (a, b, sel) commands in a small FIFO.
// It drives one command at a time onto the ALU and captures the combinational result.
// The result is returned with zero/divide-by-zero flags over a valid/ready port.
module alu_cmd_sequencer #(
    parameter int DATA_W     = 4,
    parameter int SEL_W      = 4,
    parameter int OUT_W      = 9,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    alu_cmd_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(3);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
    } cmd_t;

    cmd_t              fifoMem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wrPtr_q, rdPtr_q;
    state_t            state_q, state_d;

    logic [DATA_W-1:0] aluA_q, aluB_q;
    logic [SEL_W-1:0]  aluSel_q;
    logic              resValid_q;
    logic [OUT_W-1:0]  resData_q;
    logic [SEL_W-1:0]  resSel_q;
    logic              resZero_q;
    logic              resErr_q;
    logic [7:0]        cmdCount_q;

    logic              fifoEmpty, fifoFull;
    logic              push, pop, capture, resDone;
    cmd_t              headCmd;

    // Extra pointer bit separates full from empty when the index bits match.
    assign fifoEmpty     = (wrPtr_q == rdPtr_q);
    assign fifoFull      = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                           (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign bus.cmd_ready = !rst && !fifoFull;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign headCmd       = fifoMem_q[rdPtr_q[PTR_W-1:0]];

    // FIFO read/write pointers; a reset flushes every queued command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // FIFO storage; only the pointers decide which contents are meaningful.
    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q[PTR_W-1:0]] <= '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus pop/capture/completion strobes; a completed result may pop the next command back-to-back.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        resDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    resDone = 1'b1;
                    if (!fifoEmpty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU operand registers, result capture with flags, and the completed-handshake counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluA_q     <= '0;
            aluB_q     <= '0;
            aluSel_q   <= '0;
            resValid_q <= 1'b0;
            resData_q  <= '0;
            resSel_q   <= '0;
            resZero_q  <= 1'b0;
            resErr_q   <= 1'b0;
            cmdCount_q <= '0;
        end else begin
            if (pop) begin
                aluA_q   <= headCmd.a;
                aluB_q   <= headCmd.b;
                aluSel_q <= headCmd.sel;
            end
            if (capture) begin
                resValid_q <= 1'b1;
                resSel_q   <= aluSel_q;
                if (aluSel_q == OP_DIV && aluB_q == '0) begin
                    resData_q <= '0;
                    resZero_q <= 1'b0;
                    resErr_q  <= 1'b1;
                end else begin
                    resData_q <= bus.alu_out;
                    resZero_q <= (bus.alu_out == '0);
                    resErr_q  <= 1'b0;
                end
            end else if (resDone) begin
                resValid_q <= 1'b0;
                cmdCount_q <= cmdCount_q + 8'd1;
            end
        end
    end

    assign bus.alu_a     = aluA_q;
    assign bus.alu_b     = aluB_q;
    assign bus.alu_sel   = aluSel_q;
    assign bus.res_valid = resValid_q;
    assign bus.res_data  = resData_q;
    assign bus.res_sel   = resSel_q;
    assign bus.res_zero  = resZero_q;
    assign bus.res_err   = resErr_q;
    assign bus.busy      = (state_q != IDLE) || !fifoEmpty;
    assign bus.cmd_count = cmdCount_q;
endmodule
